// File: rtl/mfp_ahb_board_io.sv
// rtl/mfp_ahb_board_io.sv - AHB-Lite board I/O responder: LED, synchronized SW/KEY, prescaled timer with compare IRQ.
// Optional ERROR response for unmapped offsets when MFP_BOARD_IO_ERR_RESP_EN is defined.
module mfp_ahb_board_io #(
    parameter int PRESCALE    = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    input  logic [3:0]  SW,
    input  logic [1:0]  KEY,
    output logic [7:0]  LED,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE,
`ifdef MFP_BOARD_IO_ERR_RESP_EN
        ST_DATA,
        ST_ERR2
`else
        ST_DATA
`endif
    } state_t;

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    state_t                        r_state;
    state_t                        w_next_state;
    logic [3:0]                    r_addr;
    logic                          r_write;
    logic [7:0]                    r_led;
    logic [31:0]                   r_timer;
    logic [31:0]                   r_compare;
    logic [15:0]                   r_presc;
    logic                          r_status;
    logic [SYNC_STAGES-1:0][3:0]   r_sw_sync;
    logic [SYNC_STAGES-1:0][1:0]   r_key_sync;

    logic        w_req;
    logic        w_ready;
    logic        w_resp;
    logic        w_dphase;
    logic        w_wr;
    logic        w_wr_led;
    logic        w_wr_timer;
    logic        w_wr_cmp;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_match;
    logic [31:0] w_timer_inc;
    logic        w_unused;

    assign w_unused = ^{HSIZE, HADDR[31:6], HADDR[1:0]};

    assign w_req = HSEL && HREADY && HTRANS[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= 4'd0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_req && w_ready) begin
                r_addr  <= HADDR[5:2];
                r_write <= HWRITE;
            end
        end
    end

    // A new address phase is only taken in cycles where this responder drives HREADYOUT high.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b1;
        w_resp       = 1'b0;
        w_dphase     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = w_req ? ST_DATA : ST_IDLE;
            end
            ST_DATA: begin
                w_dphase = 1'b1;
`ifdef MFP_BOARD_IO_ERR_RESP_EN
                if (r_addr > 4'd5) begin
                    w_ready      = 1'b0;
                    w_resp       = 1'b1;
                    w_next_state = ST_ERR2;
                end else begin
                    w_next_state = w_req ? ST_DATA : ST_IDLE;
                end
`else
                w_next_state = w_req ? ST_DATA : ST_IDLE;
`endif
            end
`ifdef MFP_BOARD_IO_ERR_RESP_EN
            ST_ERR2: begin
                w_resp       = 1'b1;
                w_next_state = w_req ? ST_DATA : ST_IDLE;
            end
`endif
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign HREADYOUT = w_ready;
    assign HRESP     = w_resp;

    assign w_wr        = w_dphase && w_ready && r_write;
    assign w_wr_led    = w_wr && (r_addr == 4'd0);
    assign w_wr_timer  = w_wr && (r_addr == 4'd3);
    assign w_wr_cmp    = w_wr && (r_addr == 4'd4);
    assign w_wr_status = w_wr && (r_addr == 4'd5);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_sync  <= '0;
            r_key_sync <= '0;
        end else begin
            r_sw_sync  <= {r_sw_sync[SYNC_STAGES-2:0], SW};
            r_key_sync <= {r_key_sync[SYNC_STAGES-2:0], ~KEY};
        end
    end

    // Only a counting increment can raise the match flag; loads of TIMER or COMPARE never do.
    assign w_tick      = (r_presc == PS_LAST);
    assign w_timer_inc = r_timer + 32'd1;
    assign w_match     = w_tick && !w_wr_timer && (w_timer_inc == r_compare);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led     <= 8'd0;
            r_timer   <= 32'd0;
            r_presc   <= 16'd0;
            r_compare <= 32'hFFFF_FFFF;
            r_status  <= 1'b0;
        end else begin
            if (w_wr_timer) begin
                r_timer <= HWDATA;
                r_presc <= 16'd0;
            end else if (w_tick) begin
                r_timer <= w_timer_inc;
                r_presc <= 16'd0;
            end else begin
                r_presc <= r_presc + 16'd1;
            end
            if (w_wr_led) r_led <= HWDATA[7:0];
            if (w_wr_cmp) r_compare <= HWDATA;
            if (w_match) begin
                r_status <= 1'b1;
            end else if (w_wr_status && HWDATA[0]) begin
                r_status <= 1'b0;
            end
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (w_dphase) begin
            case (r_addr)
                4'd0:    HRDATA = {24'd0, r_led};
                4'd1:    HRDATA = {28'd0, r_sw_sync[SYNC_STAGES-1]};
                4'd2:    HRDATA = {30'd0, r_key_sync[SYNC_STAGES-1]};
                4'd3:    HRDATA = r_timer;
                4'd4:    HRDATA = r_compare;
                4'd5:    HRDATA = {31'd0, r_status};
                default: HRDATA = 32'd0;
            endcase
        end
    end

    assign LED = r_led;
    assign IRQ = r_status;

endmodule

// File: tb/tb_mfp_ahb_board_io.sv
// tb/tb_mfp_ahb_board_io.sv - self-checking bench for mfp_ahb_board_io with an arithmetic reference model.
module tb_mfp_ahb_board_io;

    localparam int P = 10;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = '0;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [3:0]  SW = 4'd0;
    logic [1:0]  KEY = 2'b11;
    logic [7:0]  LED;
    logic        IRQ;

    assign HREADY = HREADYOUT;

    mfp_ahb_board_io #(.PRESCALE(P), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .SW(SW), .KEY(KEY), .LED(LED), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Timer is the last loaded value plus whole prescale periods elapsed since that load.
    logic [7:0]  m_led;
    logic [31:0] m_base;
    logic [31:0] m_compare;
    int          m_since;
    logic        m_status;
    logic [5:0]  hist[$];

    function automatic logic [31:0] m_timer();
        return m_base + 32'(m_since / P);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] idx);
        logic [5:0] s;
        s = (hist.size() >= S) ? hist[hist.size() - S] : 6'd0;
        case (idx)
            4'd0:    return {24'd0, m_led};
            4'd1:    return {28'd0, s[5:2]};
            4'd2:    return {30'd0, s[1:0]};
            4'd3:    return m_timer();
            4'd4:    return m_compare;
            4'd5:    return {31'd0, m_status};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_edge(input bit wr, input logic [3:0] idx, input logic [31:0] d);
        bit matched;
        matched = 1'b0;
        if (reset) begin
            m_led = 8'd0; m_base = 32'd0; m_since = 0;
            m_compare = 32'hFFFF_FFFF; m_status = 1'b0;
            hist.delete();
        end else begin
            hist.push_back({SW, ~KEY});
            m_since++;
            if (wr && idx == 4'd3) begin
                m_base = d;
                m_since = 0;
            end else if (m_since % P == 0) begin
                matched = (m_timer() == m_compare);
            end
            if (wr && idx == 4'd0) m_led = d[7:0];
            if (wr && idx == 4'd4) m_compare = d;
            if (wr && idx == 4'd5 && d[0]) m_status = 1'b0;
            if (matched) m_status = 1'b1;
        end
    endfunction

    task automatic step(input bit wr, input logic [3:0] idx, input logic [31:0] d);
        @(posedge clk);
        model_edge(wr, idx, d);
        #1;
    endtask

    task automatic xfer(input bit wr, input logic [3:0] idx, input logic [31:0] wd,
                        input string tag, output logic [31:0] rd);
        logic [31:0] rnd;
        logic [31:0] exp;
        logic        exp_resp;
        rnd    = $urandom();
        HSEL   = 1'b1;
        HTRANS = rnd[5] ? 2'b11 : 2'b10;
        HADDR  = {rnd[31:6], idx, rnd[1:0]};
        HWRITE = wr;
        HSIZE  = rnd[4:2];
        step(1'b0, 4'd0, 32'd0);
        rnd    = $urandom();
        HSEL   = rnd[0];
        HTRANS = {1'b0, rnd[1]};
        HADDR  = rnd;
        HWDATA = wd;
        exp    = m_read(idx);
        exp_resp = 1'b0;
        @(negedge clk);
`ifdef MFP_BOARD_IO_ERR_RESP_EN
        if (idx > 4'd5) begin
            exp_resp = 1'b1;
            check({tag, "_rdy1"}, HREADYOUT, 1'b0);
            check({tag, "_resp1"}, HRESP, 1'b1);
            step(1'b0, 4'd0, 32'd0);
            @(negedge clk);
        end
`endif
        check({tag, "_rdy"}, HREADYOUT, 1'b1);
        check({tag, "_resp"}, HRESP, exp_resp);
        rd = HRDATA;
        if (!wr) check({tag, "_rdata"}, HRDATA, exp);
        check({tag, "_led"}, LED, m_led);
        check({tag, "_irq"}, IRQ, m_status);
        step(wr, idx, wd);
        HWDATA = $urandom();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] rnd;
        logic [3:0]  idx;
        int          n;
        bit          found;

        repeat (3) step(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        check("rst_led", LED, 8'h00);
        check("rst_irq", IRQ, 1'b0);
        check("rst_rdy", HREADYOUT, 1'b1);
        check("rst_resp", HRESP, 1'b0);
        check("rst_hrdata", HRDATA, 32'd0);
        reset = 1'b0;

        xfer(1'b0, 4'd0, 32'd0, "rst_rd_led", rd);   check("rst_led_val", rd, 32'h0);
        xfer(1'b0, 4'd3, 32'd0, "rst_rd_tmr", rd);   check("rst_tmr_val", rd, 32'h0);
        xfer(1'b0, 4'd4, 32'd0, "rst_rd_cmp", rd);   check("rst_cmp_val", rd, 32'hFFFF_FFFF);
        xfer(1'b0, 4'd5, 32'd0, "rst_rd_sts", rd);   check("rst_sts_val", rd, 32'h0);

        // write LED then read it in the very next address phase
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0; HWRITE = 1'b1;
        step(1'b0, 4'd0, 32'd0);
        HWDATA = 32'h0000_01A5; HWRITE = 1'b0;
        @(negedge clk);
        check("b2b_wr_rdy", HREADYOUT, 1'b1);
        step(1'b1, 4'd0, 32'h0000_01A5);
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge clk);
        check("b2b_led", LED, 8'hA5);
        check("b2b_rdata", HRDATA, 32'h0000_00A5);
        check("b2b_rdata_m", HRDATA, m_read(4'd0));
        check("b2b_rd_rdy", HREADYOUT, 1'b1);
        step(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        check("idle_hrdata", HRDATA, 32'd0);

        xfer(1'b1, 4'd3, 32'h0000_000E, "m_wr_tmr", rd);
        xfer(1'b1, 4'd4, 32'h0000_0010, "m_wr_cmp", rd);
        n = 2; found = 1'b0;
        while (n < 3 * P && !found) begin
            step(1'b0, 4'd0, 32'd0);
            n++;
            @(negedge clk);
            check("m_irq_trk", IRQ, m_status);
            if (IRQ) found = 1'b1;
        end
        check("match_latency", n, 2 * P);
        xfer(1'b0, 4'd5, 32'd0, "m_rd_sts", rd);     check("m_sts_set", rd, 32'h1);
        xfer(1'b1, 4'd5, 32'h1, "w1c", rd);
        @(negedge clk);
        check("w1c_irq", IRQ, 1'b0);

        xfer(1'b1, 4'd4, 32'h0000_0101, "race_cmp", rd);
        xfer(1'b1, 4'd3, 32'h0000_0100, "race_tmr", rd);
        n = 0;
        while ((m_since % P) != P - 2 && n < 2 * P) begin
            step(1'b0, 4'd0, 32'd0);
            n++;
        end
        xfer(1'b1, 4'd5, 32'h1, "race_w1c", rd);
        @(negedge clk);
        check("race_set_wins", IRQ, 1'b1);
        xfer(1'b1, 4'd5, 32'h1, "race_clr", rd);

        SW = 4'b1010; KEY = 2'b01;
        xfer(1'b0, 4'd1, 32'd0, "sw_early", rd);    check("sw_old", rd, 32'h0);
        xfer(1'b0, 4'd1, 32'd0, "sw_late", rd);     check("sw_new", rd, 32'hA);
        xfer(1'b0, 4'd2, 32'd0, "key_late", rd);    check("key_new", rd, 32'h2);

        xfer(1'b1, 4'd4, 32'h0000_0005, "wrap_cmp", rd);
        xfer(1'b1, 4'd3, 32'hFFFF_FFFF, "wrap_tmr", rd);
        repeat (P - 1) step(1'b0, 4'd0, 32'd0);
        xfer(1'b0, 4'd3, 32'd0, "wrap_rd", rd);     check("wrap_zero", rd, 32'h0);
        xfer(1'b0, 4'd5, 32'd0, "wrap_sts", rd);    check("wrap_noflag", rd, 32'h0);

        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0; HWRITE = 1'b1;
        step(1'b0, 4'd0, 32'd0);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h77; reset = 1'b1;
        step(1'b1, 4'd0, 32'h77);
        reset = 1'b0;
        @(negedge clk);
        check("rst_drop_led", LED, 8'h00);

        xfer(1'b1, 4'd0, 32'h0000_003C, "pre_unm", rd);
        xfer(1'b1, 4'd8, 32'h0000_00FF, "unm_wr", rd);
        check("unm_led", LED, 8'h3C);
        xfer(1'b0, 4'd8, 32'd0, "unm_rd", rd);      check("unm_zero", rd, 32'h0);

        repeat (300) begin
            rnd = $urandom();
            if (rnd[3:0] == 4'd0) begin
                SW  = 4'($urandom());
                KEY = 2'($urandom());
            end
            if (rnd[5:4] == 2'd0) begin
                repeat ($urandom_range(1, 3)) step(1'b0, 4'd0, 32'd0);
                @(negedge clk);
                check("rnd_idle_hrdata", HRDATA, 32'd0);
            end
            idx = rnd[6] ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
            if (idx == 4'd3 && rnd[8])
                xfer(rnd[7], idx, m_compare - 32'($urandom_range(1, 3)), "rnd", rd);
            else
                xfer(rnd[7], idx, $urandom(), "rnd", rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_board_io.md
Name: mfp_ahb_board_io

Overview:
- AHB-Lite responder for the board I/O of the DE0-Nano MIPSfpga build.
- Sits on the mfp_system bus (HADDR/HWDATA/HRDATA/HWRITE) opposite the core's bus initiator.
- Provides an LED register, synchronized switch and key inputs, and a prescaled 32-bit timer with a compare match flag and interrupt.
- Zero wait states on the OKAY path.

Parameters:
- PRESCALE, 10, clk cycles per timer increment (10 at 10 MHz gives a 1 us tick); legal range 1..65535.
- SYNC_STAGES, 2, synchronizer depth for SW/KEY; legal values 2 or 3.

Ports:
- clk  input  1  system clock (10 MHz PLL output)
- reset  input  1  synchronous, active-high
- HSEL  input  1  block select from the bus decoder
- HADDR  input  32  address; only HADDR[5:2] is decoded, HADDR[1:0] is ignored
- HTRANS  input  2  transfer type; bit1=1 (NONSEQ/SEQ) means an active transfer
- HWRITE  input  1  1=write, 0=read
- HSIZE  input  3  ignored; every write is a full 32-bit word
- HWDATA  input  32  write data, valid in the data phase
- HREADY  input  1  bus-wide ready
- HRDATA  output  32  read data, valid in the data phase
- HREADYOUT  output  1  responder ready
- HRESP  output  1  0=OKAY, 1=ERROR
- SW  input  4  board switches, asynchronous
- KEY  input  2  board keys, asynchronous, active-low
- LED  output  8  board LEDs
- IRQ  output  1  timer match interrupt, level, equals STATUS[0]

Behaviour:
- Address phase accepted on a clk edge when HSEL && HREADY && HTRANS[1]. On acceptance the block captures HADDR[5:2] and HWRITE, and sets data_phase=1 for the next cycle. Otherwise data_phase=0.
- Reads: HRDATA is combinational from the captured offset during the data phase. Outside the data phase HRDATA=0.
- Writes: the register update commits on the clk edge that ends the data phase (data_phase && HREADYOUT). A read data phase immediately after a write to the same register returns the new value; no forwarding is needed.
- Register map (byte offsets):
  - 0x00 LED, R/W, bits [7:0]; upper bits read 0.
  - 0x04 SW, RO, synchronized SW[3:0].
  - 0x08 KEY, RO, synchronized ~KEY[1:0]; 1 = pressed.
  - 0x0C TIMER, R/W. A write loads the value and clears the prescaler.
  - 0x10 COMPARE, R/W.
  - 0x14 STATUS, bit0 = match flag, sticky; writing 1 to bit0 clears it.
  - 0x18-0x3C unmapped: reads return 0, writes are ignored, response is OKAY (but see Optional Feature).
- Prescaler counts 0..PRESCALE-1. On the wrap cycle TIMER increments by 1, and 0xFFFFFFFF wraps to 0 with no flag.
- A TIMER write in the same cycle as a tick: the write wins, and the prescaler restarts at 0.
- Match: when TIMER increments to a value equal to COMPARE, STATUS[0] is set on the same edge. Writing TIMER or COMPARE to an equal value does not set the flag.
- If a match-set and a W1C occur in the same cycle, the set wins.
- SW/KEY pass through SYNC_STAGES flops. Read latency from a pin change is SYNC_STAGES cycles plus the data phase. No debounce.
- Reset values: LED=0, TIMER=0, prescaler=0, COMPARE=0xFFFFFFFF, STATUS=0, IRQ=0, synchronizer flops=0, HREADYOUT=1, HRESP=0, data_phase=0, HRDATA=0.
- Reset asserted during a write data phase discards that write.
- HSEL=0 or HTRANS=IDLE/BUSY: no state change; HREADYOUT=1, HRESP=0.

Optional Feature:
- Macro: MFP_BOARD_IO_ERR_RESP_EN.
- Defined: an accepted transfer to an unmapped offset gets the two-cycle AHB ERROR response.
  - Cycle 1: HREADYOUT=0, HRESP=1.
  - Cycle 2: HREADYOUT=1, HRESP=1.
  - The write is dropped and HRDATA=0.
  - A new address phase is not accepted until cycle 2 completes.
- Not defined: unmapped accesses read 0, writes are ignored, the response is OKAY, and the ERROR state logic is absent.

Test Plan:
- Reset, then read 0x00/0x0C/0x10/0x14 -> 0x00000000, 0x00000000 (TIMER read immediately after reset, before the first tick at PRESCALE cycles), 0xFFFFFFFF, 0x00000000; LED=0x00, IRQ=0, HREADYOUT=1 throughout.
- Write 0x000001A5 to 0x00, then a back-to-back read of 0x00 -> LED=0xA5 the cycle after the write data phase; HRDATA=0x000000A5 with zero wait states.
- Write TIMER=0x0000000E, COMPARE=0x00000010 -> STATUS[0]=1 and IRQ=1 exactly 2*PRESCALE cycles after the TIMER write. Write 0x1 to 0x14 -> IRQ=0 next cycle. Also verify a W1C issued on the match edge leaves STATUS[0]=1.
- Drive SW=4'b1010, KEY=2'b01 -> read 0x04=0x0000000A and read 0x08=0x00000002 once SYNC_STAGES cycles have elapsed; a read before then returns the old values.
- Write TIMER=0xFFFFFFFF with COMPARE=0x00000005 -> after PRESCALE cycles TIMER=0x00000000 and STATUS[0]=0. Assert reset during a write data phase to 0x00 -> LED stays 0x00.
- With MFP_BOARD_IO_ERR_RESP_EN defined, write 0xFF to 0x20 -> HREADYOUT/HRESP sequence 0/1 then 1/1, no register changes. Without it -> 1/0, and a read of 0x20 returns 0.
